// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
//   Definitions shared by the MIPS pipeline stages:
//     - load-type encodings carried from decode to the writeback stage
//     - writeback FSM state encoding
//     - the link register number used by jal-type instructions
//     - rf_write_en(): the regfile write-enable rule. Link instructions write
//       through the store_pc path instead, and r0 is never written.
// ---------------------------------------------------------------------------
package mips_defs;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DRAIN    = 2'd3
    } wb_state_t;

    function automatic logic rf_write_en(input logic       regwrite,
                                         input logic       link,
                                         input logic [4:0] wreg);
        return regwrite & ~link & (wreg != 5'd0);
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Combinational extraction and extension of load data from a little-endian
//   32-bit data-RAM word.
//   Ports:
//     load_type  in  3   LT_* encoding from mips_defs
//     addr       in  2   byte offset within the word
//     rdata      in  32  data-RAM read word
//     data       out 32  aligned, sign- or zero-extended value
//   LW ignores addr. Halfword loads use addr[1] only, so a misaligned halfword
//   address silently reads the enclosing aligned half.
// ---------------------------------------------------------------------------
module load_align
    import mips_defs::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        byte_sel = rdata[{addr, 3'b000} +: 8];
        data     = rdata;
        case (load_type)
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'h0000, half_sel};
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'h000000, byte_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   MIPS writeback stage. Takes retiring instructions from MEM, waits for load
//   data from the data RAM, aligns/extends it, and drives the regfile write
//   port and the jal link port with one-cycle registered pulses.
//
//   Parameter MEM_TIMEOUT: cycles allowed in WAIT_MEM before wb_err pulses and
//   the load is dropped; 0 disables the watchdog.
//
//   Optional feature macro WB_TRACE_EN: adds the debug_wb_* trace outputs,
//   registered alongside the write pulses and valid in the WRITE cycle.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     mem_valid/mem_ready retiring-instruction handshake from MEM
//     mem_pc, mem_wreg, mem_regwrite, mem_link, mem_load, mem_load_type,
//     mem_result          instruction fields (mem_result[1:0] = load offset)
//     dm_rvalid, dm_rdata data-RAM read response (single-cycle pulse)
//     flush               discard the instruction pending in WB
//     wb_wreg, wb_wdata, wb_regwrite      regfile write port
//     wb_store_pc, wb_inst_address        jal link port (regfile adds 8)
//     stall_req           upstream hold request, always ~mem_ready
//     wb_err              load-response watchdog expiry pulse
//     dbg_state           current FSM state
//
//   Handshake: an instruction transfers on a rising edge where
//   mem_valid & mem_ready & ~flush. mem_ready depends only on the FSM state
//   (never on mem_valid or flush); MEM must hold its fields while mem_valid is
//   high and mem_ready is low. flush suppresses the transfer without touching
//   mem_ready.
// ---------------------------------------------------------------------------
module wb_stage
    import mips_defs::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_wreg,
    input  logic        mem_regwrite,
    input  logic        mem_link,
    input  logic        mem_load,
    input  logic [2:0]  mem_load_type,
    input  logic [31:0] mem_result,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    input  logic        flush,
    output logic [4:0]  wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_regwrite,
    output logic        wb_store_pc,
    output logic [31:0] wb_inst_address,
    output logic        stall_req,
    output logic        wb_err,
    output wb_state_t   dbg_state
`ifdef WB_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    localparam bit WD_EN = (MEM_TIMEOUT > 0);
    localparam int CW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    wb_state_t     state_q, state_d;

    // Fields of the load waiting for its data-RAM response.
    logic [31:0]   pc_q;
    logic [4:0]    wreg_q;
    logic          regwrite_q;
    logic          link_q;
    logic [2:0]    load_type_q;
    logic [1:0]    addr_q;
    logic [CW-1:0] wcount_q;

    logic          take;      // instruction accepted this cycle
    logic          capture;   // load data accepted this cycle
    logic          timeout;   // watchdog drops the load this cycle
    logic          fire;      // next cycle is a WRITE cycle
    logic          wd_expired;
    logic [31:0]   aligned;

    // Write-port values for the upcoming WRITE cycle: either the direct
    // instruction (non-load) or the held load plus its aligned data.
    logic [31:0]   n_pc;
    logic [31:0]   n_wdata;
    logic [4:0]    n_wreg;
    logic          n_regwrite;
    logic          n_link;
    logic          n_we;

    load_align u_load_align (
        .load_type (load_type_q),
        .addr      (addr_q),
        .rdata     (dm_rdata),
        .data      (aligned)
    );

    // The last WAIT_MEM cycle is the one whose count equals MEM_TIMEOUT-1,
    // so the stage spends exactly MEM_TIMEOUT cycles waiting.
    assign wd_expired = WD_EN && (wcount_q == WD_LAST);
    assign stall_req  = ~mem_ready;
    assign dbg_state  = state_q;

    always_comb begin
        state_d   = state_q;
        mem_ready = 1'b0;
        take      = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                mem_ready = 1'b1;
                if (mem_valid && !flush) begin
                    take    = 1'b1;
                    state_d = mem_load ? ST_WAIT_MEM : ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // A response arriving with flush is simply dropped; without
                // one the response is still owed, so DRAIN swallows it.
                if (flush) begin
                    state_d = dm_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (dm_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (dm_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fire = (take & ~mem_load) | capture;
        if (capture) begin
            n_pc       = pc_q;
            n_wreg     = wreg_q;
            n_regwrite = regwrite_q;
            n_link     = link_q;
            n_wdata    = aligned;
        end else begin
            n_pc       = mem_pc;
            n_wreg     = mem_wreg;
            n_regwrite = mem_regwrite;
            n_link     = mem_link;
            n_wdata    = mem_result;
        end
        n_we = rf_write_en(n_regwrite, n_link, n_wreg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pc_q            <= '0;
            wreg_q          <= '0;
            regwrite_q      <= 1'b0;
            link_q          <= 1'b0;
            load_type_q     <= LT_LW;
            addr_q          <= '0;
            wcount_q        <= '0;
            wb_wreg         <= '0;
            wb_wdata        <= '0;
            wb_regwrite     <= 1'b0;
            wb_store_pc     <= 1'b0;
            wb_inst_address <= '0;
            wb_err          <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcount_q    <= (state_q == ST_WAIT_MEM && state_d == ST_WAIT_MEM)
                           ? wcount_q + 1'b1 : '0;
            wb_regwrite <= fire & n_we;
            wb_store_pc <= fire & n_link;
            wb_err      <= timeout;
            if (take && mem_load) begin
                pc_q        <= mem_pc;
                wreg_q      <= mem_wreg;
                regwrite_q  <= mem_regwrite;
                link_q      <= mem_link;
                load_type_q <= mem_load_type;
                addr_q      <= mem_result[1:0];
            end
            if (fire) begin
                wb_wreg         <= n_wreg;
                wb_wdata        <= n_wdata;
                wb_inst_address <= n_pc;
            end
        end
    end

`ifdef WB_TRACE_EN
    // Trace view of the regfile commit: link writes are reported as the
    // r31 <= pc+8 write the regfile actually performs.
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_rf_wen <= (fire && (n_we || n_link)) ? 4'hF : 4'h0;
            if (fire) begin
                debug_wb_pc       <= n_pc;
                debug_wb_rf_wnum  <= n_link ? LINK_REG : n_wreg;
                debug_wb_rf_wdata <= n_link ? n_pc + 32'd8 : n_wdata;
            end
        end
    end
`endif

endmodule
